// File: rtl/param_serializer.sv
// Parallel-to-serial shifter with selectable bit order and load-time parity.
// Words accepted on the last-bit cycle stream back-to-back with no idle gap.
module param_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             ser_en,
    input  logic             PAR_TYP,
    output logic             ser_data,
    output logic             ser_done,
    output logic             busy,
    output logic             par_bit
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e            r_state, w_state_d;
    logic [WIDTH-1:0]  r_shift, w_shift_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              r_data, w_data_d;
    logic              r_par, w_par_d;
    logic              w_last;
    logic              w_accept;

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_data_d  = r_data;
        w_par_d   = r_par;
        w_last    = (r_state == StShift) && (r_cnt == LastCnt);
        w_accept  = ser_en && ((r_state == StIdle) || w_last);

        if (w_accept) begin
            w_state_d = StShift;
            w_shift_d = P_DATA;
            w_cnt_d   = '0;
            w_par_d   = (^P_DATA) ^ PAR_TYP;
            w_data_d  = LSB_FIRST ? P_DATA[0] : P_DATA[WIDTH-1];
        end else if (r_state == StShift) begin
            if (w_last) begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_data_d  = 1'b0;
            end else begin
                w_cnt_d = r_cnt + CntW'(1);
                // The register holds the current bit at its edge; the next bit sits one place in.
                if (LSB_FIRST) begin
                    w_shift_d = r_shift >> 1;
                    w_data_d  = r_shift[1];
                end else begin
                    w_shift_d = r_shift << 1;
                    w_data_d  = r_shift[WIDTH-2];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_data  <= w_data_d;
            r_par   <= w_par_d;
        end
    end

    assign ser_data = r_data;
    assign ser_done = w_last;
    assign busy     = (r_state == StShift);
    assign par_bit  = r_par;

endmodule

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer: scripted scenarios plus randomized
// traffic against a word/bit-position reference model.
module tb_param_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d8_data = '0;
    logic        d8_en = 1'b0;
    logic        d8_ptyp = 1'b0;
    logic        d8_sd, d8_done, d8_busy, d8_par;
    logic [11:0] d12_data = '0;
    logic        d12_en = 1'b0;
    logic        d12_ptyp = 1'b0;
    logic        d12_sd, d12_done, d12_busy, d12_par;

    int total = 0;
    int bad = 0;

    // Reference model for the 8-bit LSB-first instance: current word and bit index.
    logic [7:0] m_word = '0;
    int         m_pos = -1;
    logic       m_par = 1'b0;

    always #5 clk = ~clk;

    param_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_d8 (
        .clk      (clk),
        .rst      (rst),
        .P_DATA   (d8_data),
        .ser_en   (d8_en),
        .PAR_TYP  (d8_ptyp),
        .ser_data (d8_sd),
        .ser_done (d8_done),
        .busy     (d8_busy),
        .par_bit  (d8_par)
    );

    param_serializer #(.WIDTH(12), .LSB_FIRST(1'b0)) u_d12 (
        .clk      (clk),
        .rst      (rst),
        .P_DATA   (d12_data),
        .ser_en   (d12_en),
        .PAR_TYP  (d12_ptyp),
        .ser_data (d12_sd),
        .ser_done (d12_done),
        .busy     (d12_busy),
        .par_bit  (d12_par)
    );

    always @(posedge clk) begin
        if (rst) begin
            m_pos = -1;
            m_par = 1'b0;
        end else if (d8_en && (m_pos == -1 || m_pos == 7)) begin
            m_word = d8_data;
            m_pos  = 0;
            m_par  = (^d8_data) ^ d8_ptyp;
        end else if (m_pos == 7) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos = m_pos + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({d8_sd, d8_busy, d8_done, d8_par} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_d8: got %b want 0000", {d8_sd, d8_busy, d8_done, d8_par});
        end
        total++;
        if ({d12_sd, d12_busy, d12_done, d12_par} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_d12: got %b want 0000", {d12_sd, d12_busy, d12_done, d12_par});
        end
        rst = 1'b0;
        tick();
    endtask

    // Expected vector order: {ser_data, busy, ser_done, par_bit}
    task automatic test_single_word();
        logic [7:0] w;
        logic [3:0] exp;
        w = 8'hAA;
        d8_data = w; d8_ptyp = 1'b0; d8_en = 1'b1;
        tick();
        d8_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {w[i], 1'b1, (i == 7), 1'b0};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL single_bit%0d: got %b want %b", i,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
            tick();
        end
        total++;
        if ({d8_sd, d8_busy, d8_done, d8_par} !== 4'b0000) begin
            bad++;
            $display("FAIL single_after: got %b want 0000", {d8_sd, d8_busy, d8_done, d8_par});
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] w;
        logic [3:0] exp;
        w = 8'hAA;
        d8_data = w; d8_ptyp = 1'b0; d8_en = 1'b1;
        tick();
        d8_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {w[i], 1'b1, (i == 7), 1'b0};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL ignore_bit%0d: got %b want %b", i,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
            if (i == 0) begin
                d8_data = 8'hF0; d8_ptyp = 1'b1; d8_en = 1'b1;
            end else begin
                d8_en = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== 4'b0000) begin
                bad++;
                $display("FAIL ignore_idle%0d: got %b want 0000", i,
                         {d8_sd, d8_busy, d8_done, d8_par});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [3:0]  exp;
        stream = {8'h81, 8'h0F};
        d8_data = 8'h0F; d8_ptyp = 1'b1; d8_en = 1'b1;
        tick();
        d8_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = {stream[i], 1'b1, (i == 7 || i == 15), 1'b1};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL b2b_bit%0d: got %b want %b", i,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
            if (i == 7) begin
                d8_data = 8'h81; d8_ptyp = 1'b1; d8_en = 1'b1;
            end else begin
                d8_en = 1'b0;
            end
            tick();
        end
        total++;
        if ({d8_sd, d8_busy, d8_done, d8_par} !== 4'b0001) begin
            bad++;
            $display("FAIL b2b_after: got %b want 0001", {d8_sd, d8_busy, d8_done, d8_par});
        end
    endtask

    task automatic test_msb_first_w12();
        logic [11:0] w;
        logic [3:0]  exp;
        w = 12'hA53;
        d12_data = w; d12_ptyp = 1'b1; d12_en = 1'b1;
        tick();
        d12_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp = {w[11-i], 1'b1, (i == 11), 1'b1};
            total++;
            if ({d12_sd, d12_busy, d12_done, d12_par} !== exp) begin
                bad++;
                $display("FAIL w12_bit%0d: got %b want %b", i,
                         {d12_sd, d12_busy, d12_done, d12_par}, exp);
            end
            tick();
        end
        total++;
        if ({d12_sd, d12_busy, d12_done, d12_par} !== 4'b0001) begin
            bad++;
            $display("FAIL w12_after: got %b want 0001", {d12_sd, d12_busy, d12_done, d12_par});
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        logic [3:0] exp;
        w = 8'hC3;
        d8_data = w; d8_ptyp = 1'b1; d8_en = 1'b1;
        tick();
        d8_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {w[i], 1'b1, 1'b0, 1'b1};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL rstmid_bit%0d: got %b want %b", i,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
            if (i == 3) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_idle%0d: got %b want 0000", i,
                         {d8_sd, d8_busy, d8_done, d8_par});
            end
            tick();
        end
        w = 8'h3C;
        d8_data = w; d8_ptyp = 1'b0; d8_en = 1'b1;
        tick();
        d8_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {w[i], 1'b1, (i == 7), 1'b0};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL rstmid_fresh%0d: got %b want %b", i,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
            tick();
        end
    endtask

    task automatic test_continuous();
        logic [7:0] w;
        logic [3:0] exp;
        int         dones;
        w = 8'h55;
        dones = 0;
        d8_data = w; d8_ptyp = 1'b0; d8_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 39) d8_en = 1'b0;
            exp = {w[c % 8], 1'b1, (c % 8 == 7), 1'b0};
            if (d8_done === 1'b1) dones++;
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL cont_c%0d: got %b want %b", c,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
        end
        tick();
        total++;
        if ({d8_sd, d8_busy, d8_done} !== 3'b000) begin
            bad++;
            $display("FAIL cont_after: got %b want 000", {d8_sd, d8_busy, d8_done});
        end
        total++;
        if (dones != 5) begin
            bad++;
            $display("FAIL cont_words: got %0d want 5", dones);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp;
        for (int c = 0; c < 400; c++) begin
            d8_en   = ($urandom_range(0, 2) == 0);
            d8_data = 8'($urandom);
            d8_ptyp = 1'($urandom);
            rst     = ($urandom_range(0, 59) == 0);
            tick();
            exp = {(m_pos >= 0) ? m_word[m_pos[2:0]] : 1'b0, (m_pos >= 0), (m_pos == 7), m_par};
            total++;
            if ({d8_sd, d8_busy, d8_done, d8_par} !== exp) begin
                bad++;
                $display("FAIL rand_c%0d: got %b want %b", c,
                         {d8_sd, d8_busy, d8_done, d8_par}, exp);
            end
        end
        rst = 1'b0;
        d8_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        tick();
        test_ignore_busy();
        test_back_to_back();
        tick();
        test_msb_first_w12();
        test_reset_midword();
        tick();
        test_continuous();
        tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
